// File: rtl/minx_bus_pkg.sv
// Shared definitions for the Pokemon Mini system bus: bus-status codes,
// bus field widths and the bus arbiter state encoding.
package minx_bus_pkg;

  localparam logic [1:0] BUS_COMMAND_IDLE      = 2'b00;
  localparam logic [1:0] BUS_COMMAND_IRQ_READ  = 2'b01;
  localparam logic [1:0] BUS_COMMAND_MEM_WRITE = 2'b10;
  localparam logic [1:0] BUS_COMMAND_MEM_READ  = 2'b11;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_GRANT,
    ARB_HANDOFF,
    ARB_RELEASE
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester found after index
// 'last' (wrapping around) wins; 'last' itself is checked last.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  int cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last) + k;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand]) begin
        winner[cand] = 1'b1;
        winner_idx   = IDX_W'(cand);
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the system bus between the s1c88 CPU and N secondary masters using
// the CPU bus_request/bus_ack handshake, round-robin fairness and a hold limit.
module bus_arbiter
  import minx_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int MAX_HOLD  = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_MASTERS-1:0]      req,
  output logic [N_MASTERS-1:0]      gnt,
  output logic                      cpu_bus_request,
  input  logic                      cpu_bus_ack,
  input  logic [23:0]               cpu_address,
  input  logic [7:0]                cpu_data_out,
  input  logic                      cpu_read,
  input  logic                      cpu_write,
  input  logic [1:0]                cpu_bus_status,
  input  logic [N_MASTERS*24-1:0]   m_address,
  input  logic [N_MASTERS*8-1:0]    m_data_out,
  input  logic [N_MASTERS-1:0]      m_read,
  input  logic [N_MASTERS-1:0]      m_write,
  input  logic [N_MASTERS*2-1:0]    m_bus_status,
  output logic [23:0]               address_out,
  output logic [7:0]                data_out,
  output logic                      read,
  output logic                      write,
  output logic [1:0]                bus_status,
  output logic                      preempt
);

  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e             state_q, state_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic                   cpu_bus_request_q, cpu_bus_request_d;
  logic                   preempt_q, preempt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       owner_q, owner_d;

  logic [N_MASTERS-1:0]   pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   owner_req;
  logic                   others_pending;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last       (last_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign owner_req      = |(req & gnt_q);
  assign others_pending = |(req & ~gnt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ARB_IDLE;
      gnt_q             <= '0;
      cpu_bus_request_q <= 1'b0;
      preempt_q         <= 1'b0;
      hold_q            <= '0;
      last_q            <= IDX_W'(N_MASTERS - 1);
      owner_q           <= '0;
    end else begin
      state_q           <= state_d;
      gnt_q             <= gnt_d;
      cpu_bus_request_q <= cpu_bus_request_d;
      preempt_q         <= preempt_d;
      hold_q            <= hold_d;
      last_q            <= last_d;
      owner_q           <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    last_d    = last_q;
    owner_d   = owner_q;

    case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (|req) state_d = ARB_REQ;
      end

      ARB_REQ: begin
        if (!(|req)) begin
          state_d = ARB_RELEASE;
        end else if (cpu_bus_ack && pick_valid) begin
          state_d = ARB_GRANT;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          last_d  = pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end

      // The ack check comes first: a CPU that takes the bus back wins outright.
      ARB_GRANT: begin
        if (!cpu_bus_ack) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end else if (!owner_req) begin
          gnt_d   = '0;
          state_d = others_pending ? ARB_HANDOFF : ARB_RELEASE;
        end else if (hold_q == HOLD_MAX && others_pending) begin
          gnt_d     = '0;
          preempt_d = 1'b1;
          state_d   = ARB_HANDOFF;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ARB_HANDOFF: begin
        gnt_d = '0;
        if (!cpu_bus_ack) begin
          state_d = ARB_IDLE;
        end else if (pick_valid) begin
          state_d = ARB_GRANT;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          last_d  = pick_idx;
          hold_d  = HOLD_W'(1);
        end else begin
          state_d = ARB_RELEASE;
        end
      end

      ARB_RELEASE: begin
        gnt_d = '0;
        if (!cpu_bus_ack) state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase

    cpu_bus_request_d = (state_d == ARB_REQ) || (state_d == ARB_GRANT) ||
                        (state_d == ARB_HANDOFF);
  end

  // Bus source follows the registered owner and the live ack so a granted
  // master sees no extra latency; gaps with the CPU off the bus go idle.
  always_comb begin
    address_out = '0;
    data_out    = '0;
    read        = 1'b0;
    write       = 1'b0;
    bus_status  = BUS_COMMAND_IDLE;
    if (!cpu_bus_ack || state_q == ARB_IDLE) begin
      address_out = cpu_address;
      data_out    = cpu_data_out;
      read        = cpu_read;
      write       = cpu_write;
      bus_status  = cpu_bus_status;
    end else if (|gnt_q) begin
      address_out = m_address[int'(owner_q)*ADDR_W +: ADDR_W];
      data_out    = m_data_out[int'(owner_q)*DATA_W +: DATA_W];
      read        = m_read[owner_q];
      write       = m_write[owner_q];
      bus_status  = m_bus_status[int'(owner_q)*2 +: 2];
    end
  end

  assign gnt             = gnt_q;
  assign cpu_bus_request = cpu_bus_request_q;
  assign preempt         = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then
// randomized masters and CPU checked every cycle against a behavioural model.
module tb_bus_arbiter;
  import minx_bus_pkg::*;

  localparam int N    = 3;
  localparam int MAXH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      gnt;
  logic              cpu_bus_request;
  logic              cpu_bus_ack = 1'b0;
  logic [23:0]       cpu_address = 24'hC0FFEE;
  logic [7:0]        cpu_data_out = 8'h5A;
  logic              cpu_read = 1'b1;
  logic              cpu_write = 1'b0;
  logic [1:0]        cpu_bus_status = BUS_COMMAND_MEM_READ;
  logic [N*24-1:0]   m_address = {24'h003000, 24'h002000, 24'h001000};
  logic [N*8-1:0]    m_data_out = {8'h33, 8'h22, 8'h11};
  logic [N-1:0]      m_read = '1;
  logic [N-1:0]      m_write = '0;
  logic [N*2-1:0]    m_bus_status = {N{BUS_COMMAND_MEM_READ}};
  logic [23:0]       address_out;
  logic [7:0]        data_out;
  logic              read;
  logic              write;
  logic [1:0]        bus_status;
  logic              preempt;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit model_on     = 1'b0;
  int ack_cnt      = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
    .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status),
    .m_address(m_address), .m_data_out(m_data_out), .m_read(m_read),
    .m_write(m_write), .m_bus_status(m_bus_status),
    .address_out(address_out), .data_out(data_out), .read(read),
    .write(write), .bus_status(bus_status), .preempt(preempt)
  );

  // Model: who holds the bus, expressed as ownership facts rather than states.
  bit m_requested = 1'b0;
  bit m_releasing = 1'b0;
  bit m_gap       = 1'b0;
  bit m_preempt   = 1'b0;
  int m_owner     = -1;
  int m_held      = 0;
  int m_last      = N - 1;

  function automatic int rrPick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit otherReq(input logic [N-1:0] r, input int ow);
    for (int i = 0; i < N; i++) if (i != ow && r[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    automatic bit rq = m_requested;
    automatic bit rl = m_releasing;
    automatic bit gp = m_gap;
    automatic bit pe = 1'b0;
    automatic int ow = m_owner;
    automatic int hd = m_held;
    automatic int ls = m_last;
    if (reset) begin
      rq = 0; rl = 0; gp = 0; ow = -1; hd = 0; ls = N - 1;
    end else if (rl) begin
      if (!cpu_bus_ack) rl = 0;
    end else if (!rq) begin
      if (req != '0) rq = 1;
    end else if (ow >= 0) begin
      if (!cpu_bus_ack) begin
        rq = 0; ow = -1;
      end else if (!req[ow]) begin
        if (otherReq(req, ow)) gp = 1;
        else begin rq = 0; rl = 1; end
        ow = -1;
      end else if (hd == MAXH && otherReq(req, ow)) begin
        pe = 1; gp = 1; ow = -1;
      end else if (hd < MAXH) begin
        hd = hd + 1;
      end
    end else if (gp) begin
      gp = 0;
      if (!cpu_bus_ack) rq = 0;
      else if (req != '0) begin ow = rrPick(req, ls); ls = ow; hd = 1; end
      else begin rq = 0; rl = 1; end
    end else begin
      if (req == '0) begin rq = 0; rl = 1; end
      else if (cpu_bus_ack) begin ow = rrPick(req, ls); ls = ow; hd = 1; end
    end
    m_requested <= rq;
    m_releasing <= rl;
    m_gap       <= gp;
    m_preempt   <= pe;
    m_owner     <= ow;
    m_held      <= hd;
    m_last      <= ls;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      automatic logic [N-1:0] eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      automatic logic [35:0] eb;
      if (!cpu_bus_ack || (!m_requested && !m_releasing))
        eb = {cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_status};
      else if (m_owner >= 0)
        eb = {m_address[m_owner*24 +: 24], m_data_out[m_owner*8 +: 8],
              m_read[m_owner], m_write[m_owner], m_bus_status[m_owner*2 +: 2]};
      else
        eb = {24'h0, 8'h0, 1'b0, 1'b0, BUS_COMMAND_IDLE};
      checkOutput("model_gnt", 64'(gnt), 64'(eg));
      checkOutput("model_bus_request", 64'(cpu_bus_request), 64'(m_requested));
      checkOutput("model_preempt", 64'(preempt), 64'(m_preempt));
      checkOutput("model_bus", 64'({address_out, data_out, read, write, bus_status}), 64'(eb));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] r, input logic a, input logic rst);
    @(posedge clk);
    #2;
    req         = r;
    cpu_bus_ack = a;
    reset       = rst;
    #1;
  endtask

  task automatic doReset();
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    model_on = 1'b1;
  endtask

  initial begin
    doReset();
    checkOutput("reset_gnt", 64'(gnt), 64'(3'b000));
    checkOutput("reset_bus_request", 64'(cpu_bus_request), 64'(1'b0));
    checkOutput("reset_preempt", 64'(preempt), 64'(1'b0));
    checkOutput("reset_bus_cpu", 64'(address_out), 64'(24'hC0FFEE));

    // Single PRC request, CPU acks three cycles after the request.
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("t1_no_request_yet", 64'(cpu_bus_request), 64'(1'b0));
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("t1_bus_request", 64'(cpu_bus_request), 64'(1'b1));
    checkOutput("t1_no_gnt", 64'(gnt), 64'(3'b000));
    applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t1_gnt_wait", 64'(gnt), 64'(3'b000));
    checkOutput("t1_idle_bus", 64'(bus_status), 64'(BUS_COMMAND_IDLE));
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t1_gnt", 64'(gnt), 64'(3'b001));
    checkOutput("t1_prc_addr", 64'(address_out), 64'(24'h001000));
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("t1_gnt_held", 64'(gnt), 64'(3'b001));
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("t1_release_gnt", 64'(gnt), 64'(3'b000));
    checkOutput("t1_release_req", 64'(cpu_bus_request), 64'(1'b0));
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("t1_bus_cpu", 64'(address_out), 64'(24'hC0FFEE));
    applyStimulus(3'b000, 1'b0, 1'b0);

    // Two masters request together; master 0 wins, then a one-cycle gap.
    doReset();
    applyStimulus(3'b011, 1'b0, 1'b0);
    applyStimulus(3'b011, 1'b0, 1'b0);
    applyStimulus(3'b011, 1'b1, 1'b0);
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t2_first_gnt", 64'(gnt), 64'(3'b001));
    applyStimulus(3'b010, 1'b1, 1'b0);
    applyStimulus(3'b010, 1'b1, 1'b0);
    checkOutput("t2_gap_gnt", 64'(gnt), 64'(3'b000));
    checkOutput("t2_gap_bus", 64'({read, write, bus_status}), 64'({1'b0, 1'b0, BUS_COMMAND_IDLE}));
    applyStimulus(3'b010, 1'b1, 1'b0);
    checkOutput("t2_second_gnt", 64'(gnt), 64'(3'b010));
    checkOutput("t2_second_addr", 64'(address_out), 64'(24'h002000));
    applyStimulus(3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);

    // Hold limit: master 0 keeps the bus for MAXH cycles, then is preempted.
    doReset();
    applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t3_gnt_start", 64'(gnt), 64'(3'b001));
    for (int k = 4; k <= 10; k++) begin
      applyStimulus(3'b011, 1'b1, 1'b0);
      checkOutput("t3_gnt_hold", 64'({gnt, preempt}), 64'({3'b001, 1'b0}));
    end
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t3_preempt", 64'({gnt, preempt}), 64'({3'b000, 1'b1}));
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkOutput("t3_gnt_m1", 64'({gnt, preempt}), 64'({3'b010, 1'b0}));
    applyStimulus(3'b001, 1'b1, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t3_gap", 64'(gnt), 64'(3'b000));
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t3_gnt_back", 64'(gnt), 64'(3'b001));

    // Lone requester is never preempted.
    for (int k = 0; k < 100; k++) begin
      applyStimulus(3'b001, 1'b1, 1'b0);
      checkOutput("t4_lone_owner", 64'({gnt, preempt}), 64'({3'b001, 1'b0}));
    end

    // CPU pulls ack during a grant.
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("t5_bus_cpu", 64'(address_out), 64'(24'hC0FFEE));
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("t5_abort", 64'({gnt, cpu_bus_request}), 64'({3'b000, 1'b0}));
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("t5_rerequest", 64'(cpu_bus_request), 64'(1'b1));
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);

    // Reset in the middle of a grant.
    doReset();
    applyStimulus(3'b001, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t6_gnt", 64'(gnt), 64'(3'b001));
    applyStimulus(3'b001, 1'b1, 1'b1);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t6_reset_out", 64'({gnt, cpu_bus_request, preempt}), 64'({3'b000, 1'b0, 1'b0}));
    checkOutput("t6_reset_bus", 64'(address_out), 64'(24'hC0FFEE));
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t6_fresh_req", 64'(cpu_bus_request), 64'(1'b1));
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("t6_fresh_gnt", 64'(gnt), 64'(3'b001));

    // Random masters, a CPU with variable ack latency and rare violations.
    doReset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #2;
      reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 11) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
        m_address[i*24 +: 24]   = 24'($urandom);
        m_data_out[i*8 +: 8]    = 8'($urandom);
        m_read[i]               = 1'($urandom);
        m_write[i]              = 1'($urandom);
        m_bus_status[i*2 +: 2]  = 2'($urandom);
      end
      if (cpu_bus_ack != cpu_bus_request) begin
        if (ack_cnt == 0) begin
          cpu_bus_ack = cpu_bus_request;
          ack_cnt     = $urandom_range(0, 3);
        end else begin
          ack_cnt--;
        end
      end else if (cpu_bus_ack && $urandom_range(0, 199) == 0) begin
        cpu_bus_ack = 1'b0;
      end
      cpu_address    = 24'($urandom);
      cpu_data_out   = 8'($urandom);
      cpu_read       = 1'($urandom);
      cpu_write      = 1'($urandom);
      cpu_bus_status = 2'($urandom);
    end

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
